pipelined_instruction_decode: RTL
=================================

# pipelined_instruction_decode

Parametrised, pipelined decode stage for the multi-cycle/pipelined datapath: it owns the register file, generates the extended immediate, selects the write-back source and registers decoded operands into an ID/EX pipeline register with a valid/ready handshake. It sits between instruction fetch (upstream handshake) and execute (downstream handshake), and receives write-back traffic from the memory/write-back stage. Compared with the combinational decoder it adds:
- generic data width and register count;
- same-cycle write-to-read bypass;
- stall-safe operand refresh;
- flush.

## Interface
Parameters:
- DATA_WIDTH, 32, width of register, ALU and memory data (≥32).
- REG_ADDR_W, 5, register address width; register count = 2^REG_ADDR_W.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction: opcode [31:26], rs [25:21], rd [20:16], rt [15:11], imm [15:0]. Only the low REG_ADDR_W bits of each register field are used.
- In_valid  in  1  Instr valid from fetch.
- In_ready  out  1  decode can accept Instr this cycle.
- RF_Bsel  in  1  B-operand address: 0 = rt, 1 = rd; sampled with Instr.
- Flush  in  1  discard pipeline register contents.
- RF_WrEn  in  1  write-back enable.
- RF_WrAddr  in  REG_ADDR_W  write-back destination.
- RF_WrData_sel  in  1  write source: 1 = ALU_out, 0 = MEM_out.
- ALU_out  in  DATA_WIDTH  ALU result.
- MEM_out  in  DATA_WIDTH  memory read data.
- Out_valid  out  1  pipeline register holds a valid decoded instruction.
- Out_ready  in  1  execute accepts the output this cycle.
- Opcode  out  6  registered opcode.
- Rd  out  REG_ADDR_W  registered destination field.
- Immed  out  DATA_WIDTH  registered extended immediate.
- RF_A  out  DATA_WIDTH  registered rs operand.
- RF_B  out  DATA_WIDTH  registered rt/rd operand.

## Operation
- Register file: 2^REG_ADDR_W × DATA_WIDTH, written on the rising edge when RF_WrEn = 1.
  - Write data = RF_WrData_sel ? ALU_out : MEM_out.
  - R0 reads 0 always; writes to R0 are ignored.
- Immediate extension by opcode:
  - Sign-extend imm to DATA_WIDTH: beq 000000, bne 000001, lb 000011, sb 000111, lw 001111, sw 011111, addi 110000, li 111000, b 111111.
  - lui 111001: imm placed at [31:16], all other bits 0.
  - Zero-extend: andi 110010, ori 110011.
  - Any other opcode: Immed = 0.
- Read bypass: if RF_WrEn = 1, RF_WrAddr ≠ 0 and RF_WrAddr equals a source address being read, the read returns the write data of the same cycle, not the stale array value.
- Accept: transfer occurs when In_valid && In_ready. On transfer, the pipeline register loads Opcode, Rd, Immed, RF_A, RF_B and the source addresses, and Out_valid is set to 1.
- Ready: In_ready = !Out_valid || Out_ready.
- Stall (Out_valid && !Out_ready):
  - Outputs hold.
  - Operand refresh: if a write-back targets a held source register (≠ 0), the matching RF_A/RF_B is updated with the write data at that edge. Both operands update if both match.
- Drain: Out_valid && Out_ready with no new transfer sets Out_valid to 0. Data outputs hold their last value.
- Flush: Out_valid goes to 0 at the next edge and takes priority over a simultaneous accept; In_ready is still computed normally. Register file writes proceed during flush.

## Timing
- Reset (asynchronous, active-low):
  - All registers, RF_A, RF_B and Immed reset to 0.
  - Opcode and Rd reset to 0; Out_valid resets to 0.
  - In_ready = 1 immediately after reset.
- Reset asserted mid-operation clears everything at once. A write-back in that cycle is lost.
- Latency: 1 cycle from accepted Instr to Out_valid. Sustained throughput is 1 instruction/cycle while Out_ready = 1.
- Write then read: a write at edge N is visible to an instruction accepted at edge N (via bypass) and to every later instruction.
- In_ready is combinational from Out_valid and Out_ready. Every other output is registered.

## Test plan
- Reset with Reset = 0 → all outputs 0, Out_valid = 0, In_ready = 1. Then write R3 = 0x12345678 (RF_WrData_sel = 1) and decode addi rs = 3, imm 0x8000 → RF_A = 0x12345678, Immed = 0xFFFF8000.
- lui imm 0xABCD → Immed = 0xABCD0000. ori imm 0xF00F → 0x0000F00F. Opcode 010101 → Immed = 0.
- Write R0 = 0xFFFFFFFF, then read rs = 0 → RF_A = 0.
- Same-cycle bypass: accept Instr with rs = 5 in the cycle MEM_out = 0xCAFE0000 is written to R5 (RF_WrData_sel = 0) → RF_A = 0xCAFE0000 one cycle later.
- Stall: hold Out_ready = 0 with RF_B from rt = 7 → In_ready = 0 and outputs hold. Write R7 = 0x55 during the stall → RF_B becomes 0x55 next cycle. Release Out_ready → next Instr is accepted.
- Flush and accept in the same cycle → Out_valid = 0 next cycle. An accept without flush in the following cycle → Out_valid = 1.

Source files
------------

// File: rtl/pipelined_instruction_decode.sv
// Decode stage: register file with same-cycle write bypass, immediate extension
// and an ID/EX pipeline register behind a valid/ready handshake.
module pipelined_instruction_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           Instr,
  input  logic                  In_valid,
  output logic                  In_ready,
  input  logic                  RF_Bsel,
  input  logic                  Flush,
  input  logic                  RF_WrEn,
  input  logic [REG_ADDR_W-1:0] RF_WrAddr,
  input  logic                  RF_WrData_sel,
  input  logic [DATA_WIDTH-1:0] ALU_out,
  input  logic [DATA_WIDTH-1:0] MEM_out,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [5:0]            Opcode,
  output logic [REG_ADDR_W-1:0] Rd,
  output logic [DATA_WIDTH-1:0] Immed,
  output logic [DATA_WIDTH-1:0] RF_A,
  output logic [DATA_WIDTH-1:0] RF_B
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  logic [5:0]            opcode_d;
  logic [15:0]           imm;
  logic [REG_ADDR_W-1:0] rs_addr, rd_addr, rt_addr, b_addr;
  logic [REG_ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_WIDTH-1:0] wr_data, rd_a, rd_b, immed_d;
  logic [DATA_WIDTH-1:0] sext, zext;
  logic                  wr_hit, accept, load, stall;

  assign opcode_d = Instr[31:26];
  assign imm      = Instr[15:0];
  assign rs_addr  = Instr[21 +: REG_ADDR_W];
  assign rd_addr  = Instr[16 +: REG_ADDR_W];
  assign rt_addr  = Instr[11 +: REG_ADDR_W];
  assign b_addr   = RF_Bsel ? rd_addr : rt_addr;

  assign wr_data = RF_WrData_sel ? ALU_out : MEM_out;
  assign wr_hit  = RF_WrEn && (RF_WrAddr != '0);

  assign In_ready = !Out_valid || Out_ready;
  assign accept   = In_valid && In_ready;
  assign load     = accept && !Flush;
  assign stall    = Out_valid && !Out_ready;

  // R0 is never written, so the explicit zero read only guards against reset-free use
  always_comb begin
    rd_a = (rs_addr == '0) ? '0 : rf[rs_addr];
    rd_b = (b_addr == '0) ? '0 : rf[b_addr];
    if (wr_hit && (RF_WrAddr == rs_addr)) rd_a = wr_data;
    if (wr_hit && (RF_WrAddr == b_addr))  rd_b = wr_data;
  end

  assign sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign zext = DATA_WIDTH'(imm);

  always_comb begin
    immed_d = '0;
    case (opcode_d)
      6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111,
      6'b011111, 6'b110000, 6'b111000, 6'b111111: immed_d = sext;
      6'b111001:                                  immed_d = zext << 16;
      6'b110010, 6'b110011:                       immed_d = zext;
      default:                                    immed_d = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_hit) begin
      rf[RF_WrAddr] <= wr_data;
    end
  end

  // A flushed accept still completes the upstream handshake; the instruction is dropped
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Out_valid <= 1'b0;
      Opcode    <= '0;
      Rd        <= '0;
      Immed     <= '0;
      RF_A      <= '0;
      RF_B      <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
    end else begin
      if (Flush)           Out_valid <= 1'b0;
      else if (accept)     Out_valid <= 1'b1;
      else if (Out_ready)  Out_valid <= 1'b0;

      if (load) begin
        Opcode   <= opcode_d;
        Rd       <= rd_addr;
        Immed    <= immed_d;
        RF_A     <= rd_a;
        RF_B     <= rd_b;
        a_addr_q <= rs_addr;
        b_addr_q <= b_addr;
      end else if (stall && wr_hit) begin
        if (RF_WrAddr == a_addr_q) RF_A <= wr_data;
        if (RF_WrAddr == b_addr_q) RF_B <= wr_data;
      end
    end
  end

endmodule
